// File: rtl/dma_priority_arb.sv
// NUM_CH-channel DMA arbiter: request sampling, HRQ/HLDA/service handshake, fixed or rotating priority.
// Optional starvation aging is compiled in with `define DMA_PRIO_AGE_EN.
module dma_priority_arb #(
    parameter int NUM_CH    = 4,
    parameter int CHW       = $clog2(NUM_CH),
    parameter int AGE_LIMIT = 7
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic [NUM_CH-1:0] sw_req,
    input  logic [NUM_CH-1:0] mask,
    input  logic              dreq_active_low,
    input  logic              dack_active_low,
    input  logic              rotate_en,
    input  logic              ctrl_disable,
    input  logic              HLDA,
    input  logic              svc_done,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    output logic              grant_valid,
    output logic [CHW-1:0]    grant_ch
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_GRANT   = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    localparam logic [CHW:0]   NCH  = (CHW+1)'(NUM_CH);
    localparam logic [CHW-1:0] LAST = CHW'(NUM_CH - 1);

    logic [1:0]        r_state;
    logic [NUM_CH-1:0] r_req_q;
    logic [NUM_CH-1:0] r_grant_oh;
    logic [CHW-1:0]    r_grant_ch;
    logic [CHW-1:0]    r_rr_ptr;
    logic              r_hrq;
    logic              r_grant_valid;

    logic [CHW-1:0]    w_base;
    logic [CHW:0]      w_idx;
    logic [CHW-1:0]    w_win;
    logic              w_found;
    logic [NUM_CH-1:0] w_win_oh;
    logic [NUM_CH-1:0] w_aged;
    logic              w_svc_complete;

    assign w_svc_complete = (r_state == S_GRANT) && svc_done;

`ifdef DMA_PRIO_AGE_EN
    localparam int             AW      = $clog2(AGE_LIMIT + 1);
    localparam logic [AW-1:0]  AGE_MAX = AW'(AGE_LIMIT);

    logic [NUM_CH-1:0][AW-1:0] r_age;

    always_comb begin
        w_aged = '0;
        for (int i = 0; i < NUM_CH; i++)
            w_aged[i] = r_req_q[i] && (r_age[i] == AGE_MAX);
    end

    // Losers still requesting at service completion age; the winner starts over.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_age <= '0;
        end else if (w_svc_complete) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (r_grant_oh[i])
                    r_age[i] <= '0;
                else if (r_req_q[i] && (r_age[i] != AGE_MAX))
                    r_age[i] <= r_age[i] + AW'(1);
            end
        end
    end
`else
    wire w_unused_age = |AGE_LIMIT;
    assign w_aged = '0;
`endif

    assign w_base = rotate_en ? r_rr_ptr : '0;

    // Search from w_base, wrapping by subtraction so no index >= NUM_CH is ever formed.
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_idx = {1'b0, w_base} + (CHW+1)'(i);
            if (w_idx >= NCH)
                w_idx = w_idx - NCH;
            if (!w_found && r_req_q[w_idx[CHW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[CHW-1:0];
            end
        end
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (w_aged[i])
                w_win = CHW'(i);
    end

    always_comb begin
        w_win_oh = '0;
        for (int i = 0; i < NUM_CH; i++)
            w_win_oh[i] = (w_win == CHW'(i));
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state       <= S_IDLE;
            r_req_q       <= '0;
            r_grant_oh    <= '0;
            r_grant_ch    <= '0;
            r_rr_ptr      <= '0;
            r_hrq         <= 1'b0;
            r_grant_valid <= 1'b0;
        end else begin
            r_req_q <= ((DREQ ^ {NUM_CH{dreq_active_low}}) | sw_req) & ~mask;
            case (r_state)
                S_IDLE: begin
                    if ((|r_req_q) && !ctrl_disable) begin
                        r_state <= S_REQ;
                        r_hrq   <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (HLDA) begin
                        if (|r_req_q) begin
                            r_grant_ch    <= w_win;
                            r_grant_oh    <= w_win_oh;
                            r_grant_valid <= 1'b1;
                            r_state       <= S_GRANT;
                        end else begin
                            r_hrq   <= 1'b0;
                            r_state <= S_RELEASE;
                        end
                    end
                end
                S_GRANT: begin
                    // Completion wins over a simultaneous HLDA drop; only completion rotates.
                    if (svc_done || !HLDA) begin
                        r_grant_oh    <= '0;
                        r_grant_valid <= 1'b0;
                        r_hrq         <= 1'b0;
                        r_state       <= S_RELEASE;
                        if (svc_done)
                            r_rr_ptr <= (r_grant_ch == LAST) ? '0 : r_grant_ch + CHW'(1);
                    end
                end
                default: begin
                    r_hrq <= 1'b0;
                    if (!HLDA)
                        r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign HRQ         = r_hrq;
    assign grant_valid = r_grant_valid;
    assign grant_ch    = r_grant_ch;
    assign DACK        = r_grant_oh ^ {NUM_CH{dack_active_low}};

endmodule

// File: tb/tb_dma_priority_arb.sv
// Randomized scoreboard bench for dma_priority_arb (3 channels, non-power-of-2 wrap).
module tb_dma_priority_arb;

    localparam int N   = 3;
    localparam int CW  = $clog2(N);
    localparam int AGE = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  dreq, sw_req, mask, dack;
    logic          dreq_al, dack_al, rot, cdis, hlda, svc;
    logic          hrq, gv;
    logic [CW-1:0] gch;

    dma_priority_arb #(.NUM_CH(N), .AGE_LIMIT(AGE)) dut (
        .CLK(clk), .RESET_N(rst_n), .DREQ(dreq), .sw_req(sw_req), .mask(mask),
        .dreq_active_low(dreq_al), .dack_active_low(dack_al), .rotate_en(rot),
        .ctrl_disable(cdis), .HLDA(hlda), .svc_done(svc),
        .HRQ(hrq), .DACK(dack), .grant_valid(gv), .grant_ch(gch)
    );

    always #5 clk = ~clk;

    typedef struct { int ch; logic [N-1:0] dack; } exp_t;
    exp_t sb[$];

    int n_chk = 0;
    int n_fail = 0;

    // Reference state: rotation pointer and per-channel age, kept as plain integers.
    int m_rr = 0;
    int m_age[N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_win(input logic [N-1:0] r, input bit rotating);
`ifdef DMA_PRIO_AGE_EN
        for (int c = 0; c < N; c++)
            if (r[c] && m_age[c] == AGE) return c;
`endif
        for (int k = 0; k < N; k++) begin
            int c;
            c = rotating ? (m_rr + k) % N : k;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_service(input int ch, input logic [N-1:0] r);
        m_rr = (ch + 1) % N;
        for (int c = 0; c < N; c++) begin
            if (c == ch) m_age[c] = 0;
            else if (r[c] && m_age[c] < AGE) m_age[c]++;
        end
    endtask

    task automatic model_reset();
        m_rr = 0;
        for (int c = 0; c < N; c++) m_age[c] = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int ch, input bit kal);
        exp_t e;
        logic [N-1:0] one;
        one = N'(1);
        e.ch = ch;
        e.dack = (one << ch) ^ {N{kal}};
        sb.push_back(e);
    endtask

    task automatic wait_gv(input string name);
        int n;
        n = 0;
        while (!gv && n < 20) begin tick(); n++; end
        chk(name, 32'(gv), 1);
    endtask

    task automatic cleanup();
        mask = '1; hlda = 1'b0; cdis = 1'b0; svc = 1'b0;
        repeat (3) tick();
    endtask

    // One full arbitration: configure with everything masked, unmask, handshake, finish or abort.
    task automatic episode(input logic [N-1:0] act, input logic [N-1:0] sw, input logic [N-1:0] msk,
                           input bit r, input bit dal, input bit kal, input bit abort_it, input int force_ch);
        logic [N-1:0] eff;
        int ch;
        eff = (act | sw) & ~msk;
        ch = model_win(eff, r);
        if (force_ch >= 0) ch = force_ch;
        push_exp(ch, kal);
        dreq = act ^ {N{dal}}; sw_req = sw; rot = r; dreq_al = dal; dack_al = kal;
        tick();
        mask = msk;
        tick();
        chk("hrq_early", 32'(hrq), 0);
        tick();
        chk("hrq_latency", 32'(hrq), 1);
        repeat ($urandom_range(0, 3)) tick();
        hlda = 1'b1;
        wait_gv("grant_timeout");
        if ($urandom_range(0, 1) == 1) cdis = 1'b1;
        repeat ($urandom_range(0, 3)) tick();
        chk("grant_held", 32'(gv), 1);
        if (abort_it) begin
            hlda = 1'b0;
            tick();
        end else begin
            svc = 1'b1;
            tick();
            svc = 1'b0;
            model_service(ch, eff);
        end
        chk("hrq_release", 32'(hrq), 0);
        chk("gv_release", 32'(gv), 0);
        cleanup();
    endtask

    // Monitor: pop an expectation each time a grant appears; idle DACK must be all-inactive.
    bit prev_gv = 1'b0;
    always @(negedge clk) begin
        if (gv && !prev_gv) begin
            if (sb.size() == 0) chk("unexpected_grant", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("grant_ch", 32'(gch), 32'(e.ch));
                chk("dack_grant", 32'(dack), 32'(e.dack));
            end
        end else if (!gv) begin
            chk("dack_idle", 32'(dack), 32'({N{dack_al}}));
        end
        prev_gv = gv;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired checks=%0d", n_chk);
        $fatal(1);
    end

    initial begin
        logic [N-1:0] a, s, m;
        model_reset();
        rst_n = 1'b0; dreq = '0; sw_req = '0; mask = '1; dreq_al = 1'b0; dack_al = 1'b1;
        rot = 1'b0; cdis = 1'b0; hlda = 1'b0; svc = 1'b0;
        repeat (2) tick();
        chk("rst_hrq", 32'(hrq), 0);
        chk("rst_gv", 32'(gv), 0);
        chk("rst_gch", 32'(gch), 0);
        chk("rst_dack", 32'(dack), 32'({N{1'b1}}));
        rst_n = 1'b1;
        dack_al = 1'b0;
        tick();

        // Rotating with all requesting: 0,1,2,0 then 1, then ch2 aborted and re-granted.
        episode('0, '1, '0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        episode('0, '1, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        episode('0, '1, '0, 1'b1, 1'b0, 1'b0, 1'b0, 2);
        episode('0, '1, '0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        episode('0, '1, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        episode('0, '1, '0, 1'b1, 1'b0, 1'b0, 1'b1, 2);
        episode('0, '1, '0, 1'b1, 1'b0, 1'b0, 1'b0, 2);
        // Fixed priority on hardware requests, then both polarities inverted.
        episode(3'b110, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        episode(3'b001, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0, -1);

        // ctrl_disable blocks IDLE->REQ only.
        cdis = 1'b1; sw_req = 3'b100; dreq = '0; dreq_al = 1'b0; mask = '0;
        repeat (4) tick();
        chk("cdis_block", 32'(hrq), 0);
        cdis = 1'b0;
        push_exp(model_win(3'b100, rot), dack_al);
        repeat (2) tick();
        chk("cdis_release", 32'(hrq), 1);
        hlda = 1'b1;
        wait_gv("cdis_grant_timeout");
        svc = 1'b1; tick(); svc = 1'b0;
        model_service(2, 3'b100);
        cleanup();

        // Request withdrawn before HLDA: release with no grant.
        sw_req = 3'b001; mask = '0;
        repeat (2) tick();
        mask = '1;
        tick();
        hlda = 1'b1;
        tick();
        chk("withdraw_hrq", 32'(hrq), 0);
        chk("withdraw_gv", 32'(gv), 0);
        cleanup();

        // Grant survives masking; async reset mid-grant clears everything at once.
        sw_req = '1; rot = 1'b1; mask = '0;
        push_exp(model_win('1, 1'b1), dack_al);
        repeat (2) tick();
        hlda = 1'b1;
        wait_gv("rst_grant_timeout");
        mask = '1;
        repeat (2) tick();
        chk("mask_hold", 32'(gv), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_hrq", 32'(hrq), 0);
        chk("midrst_gv", 32'(gv), 0);
        chk("midrst_dack", 32'(dack), 32'({N{dack_al}}));
        model_reset();
        hlda = 1'b0;
        tick();
        rst_n = 1'b1;
        cleanup();

        // Randomized episodes against the reference model.
        for (int i = 0; i < 40; i++) begin
            a = N'($urandom);
            s = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            m = N'($urandom) & N'($urandom);
            if (((a | s) & ~m) == '0) begin
                int c;
                c = $urandom_range(0, N - 1);
                s[c] = 1'b1;
                m[c] = 1'b0;
            end
            episode(a, s, m, 1'($urandom), 1'($urandom), 1'($urandom),
                    $urandom_range(0, 3) == 0, -1);
        end

        repeat (3) tick();
        chk("sb_empty", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
